// File: rtl/snitch_perf_counter_ctrl.sv
// snitch_perf_counter_ctrl: bank of programmable per-hart event/cycle counters
// behind a register port with a one-deep registered response.
module snitch_perf_counter_ctrl #(
    parameter int unsigned NumCores    = 8,
    parameter int unsigned NumCounters = 4,
    parameter int unsigned AddrWidth   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumCores*7-1:0] core_events_i,
    input  logic                  freeze_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic                  overflow_irq_o
);
    localparam logic [AddrWidth:0] Limit = (AddrWidth + 1)'(NumCounters * 8);

    // Bit 7 of each hart's vector is a constant 0 so evsel 7 never reads a real strobe.
    logic [NumCores-1:0][7:0]     events;
    logic [NumCounters-1:0]       enable, irq_en, overflow, sel, inc, wr_cfg, wr_val;
    logic [NumCounters-1:0][2:0]  evsel;
    logic [NumCounters-1:0][7:0]  hart;
    logic [NumCounters-1:0][31:0] value;
    logic                         accept, error;
    logic [31:0]                  rdata;

    for (genvar h = 0; h < NumCores; h++) begin : g_ev
        assign events[h] = {1'b0, core_events_i[h*7 +: 7]};
    end

    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign error       = req_addr_i[1:0] != 2'b0 || {1'b0, req_addr_i} >= Limit;

    always_comb begin
        rdata  = '0;
        sel    = '0;
        inc    = '0;
        wr_cfg = '0;
        wr_val = '0;
        for (int i = 0; i < NumCounters; i++) begin
            sel[i] = evsel[i] == 3'd7;
            for (int h = 0; h < NumCores; h++)
                if (hart[i] == 8'(h)) sel[i] = sel[i] | events[h][evsel[i]];
            inc[i] = enable[i] && !freeze_i && sel[i];
            if (req_addr_i[AddrWidth-1:3] == (AddrWidth - 3)'(i)) begin
                rdata = req_addr_i[2] ? value[i] :
                        {overflow[i], 15'b0, hart[i], 1'b0, evsel[i], 2'b0, irq_en[i], enable[i]};
                wr_cfg[i] = accept && req_write_i && !error && !req_addr_i[2];
                wr_val[i] = accept && req_write_i && !error && req_addr_i[2];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable         <= '0;
            irq_en         <= '0;
            overflow       <= '0;
            evsel          <= '0;
            hart           <= '0;
            value          <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_rdata_o    <= '0;
            rsp_error_o    <= 1'b0;
            overflow_irq_o <= 1'b0;
        end else begin
            overflow_irq_o <= |(overflow & irq_en);
            if (accept) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= (req_write_i || error) ? 32'b0 : rdata;
                rsp_error_o <= error;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            for (int i = 0; i < NumCounters; i++) begin
                if (wr_val[i]) value[i] <= req_wdata_i;
                else if (inc[i]) value[i] <= value[i] + 32'd1;
                if (wr_cfg[i]) begin
                    enable[i] <= req_wdata_i[0];
                    irq_en[i] <= req_wdata_i[1];
                    evsel[i]  <= req_wdata_i[6:4];
                    hart[i]   <= req_wdata_i[15:8];
                end
                // A wrap in the same cycle beats a write-1-clear.
                if (!wr_val[i] && inc[i] && &value[i]) overflow[i] <= 1'b1;
                else if (wr_cfg[i] && req_wdata_i[31]) overflow[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snitch_perf_counter_ctrl.sv
// tb_snitch_perf_counter_ctrl: directed and randomized checks against a
// cycle-level behavioural model of the counter bank and register port.
module tb_snitch_perf_counter_ctrl;
    localparam int NC = 8;
    localparam int NK = 4;

    logic            clk = 0, rst_ni = 0;
    logic [NC*7-1:0] ev = '0;
    logic            freeze = 0, req_valid = 0, req_write = 0, rsp_ready = 1;
    logic [7:0]      req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic            req_ready, rsp_valid, rsp_error, irq;
    logic [31:0]     rsp_rdata;
    int              n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    snitch_perf_counter_ctrl #(.NumCores(NC), .NumCounters(NK), .AddrWidth(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .core_events_i(ev), .freeze_i(freeze),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
        .overflow_irq_o(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: counters as plain integers, responses as expected outputs.
    int unsigned m_val[NK];
    bit          m_en[NK], m_ie[NK], m_ov[NK];
    int          m_sel[NK], m_hart[NK];
    bit          e_v, e_e, e_irq;
    logic [31:0] e_d;

    function automatic logic [31:0] cfg_word(input int i);
        return {m_ov[i], 15'b0, 8'(m_hart[i]), 1'b0, 3'(m_sel[i]), 2'b0, m_ie[i], m_en[i]};
    endfunction

    always @(posedge clk or negedge rst_ni) begin : model
        bit acc, err, nirq;
        bit cnt[NK];
        int a, k;
        if (!rst_ni) begin
            for (int i = 0; i < NK; i++) begin
                m_val[i] = 0; m_en[i] = 0; m_ie[i] = 0; m_ov[i] = 0; m_sel[i] = 0; m_hart[i] = 0;
            end
            e_v = 0; e_e = 0; e_d = 0; e_irq = 0;
        end else begin
            a = int'(req_addr);
            k = a / 8;
            nirq = 0;
            for (int i = 0; i < NK; i++) nirq |= m_ov[i] && m_ie[i];
            acc = req_valid && (!e_v || rsp_ready);
            err = (a % 4 != 0) || (a >= NK * 8);
            for (int i = 0; i < NK; i++)
                cnt[i] = m_en[i] && !freeze &&
                         (m_sel[i] == 7 || (m_hart[i] < NC && ev[m_hart[i] * 7 + m_sel[i]]));
            if (acc) begin
                e_v = 1;
                e_e = err;
                e_d = (err || req_write) ? 32'd0 : (a % 8 == 4 ? m_val[k] : cfg_word(k));
                if (req_write && !err) begin
                    if (a % 8 == 4) begin
                        m_val[k] = req_wdata;
                        cnt[k]   = 0;
                    end else begin
                        m_en[k]   = req_wdata[0];
                        m_ie[k]   = req_wdata[1];
                        m_sel[k]  = int'(req_wdata[6:4]);
                        m_hart[k] = int'(req_wdata[15:8]);
                        if (req_wdata[31]) m_ov[k] = 0;
                    end
                end
            end else if (rsp_ready) begin
                e_v = 0;
            end
            for (int i = 0; i < NK; i++)
                if (cnt[i]) begin
                    if (m_val[i] == 32'hFFFF_FFFF) m_ov[i] = 1;
                    m_val[i]++;
                end
            e_irq = nirq;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_ni) begin
            chk("rsp_valid", rsp_valid, e_v);
            chk("rsp_error", rsp_error, e_e);
            chk("rsp_rdata", rsp_rdata, e_d);
            chk("req_ready", req_ready, !e_v || rsp_ready);
            chk("irq", irq, e_irq);
        end
    end

    task automatic req(input bit w, input logic [7:0] a, input logic [31:0] d);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic noise(input bit b);
        ev = (NC * 7)'({$urandom, $urandom});
        ev[2 * 7 + 3] = b;
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d, d0;
        bit   [7:0]  pat;
        int          r;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_irq", irq, 0);
        rst_ni = 1;
        @(negedge clk);

        req(0, 8'h00, 0);
        chk("rst_cfg0", rsp_rdata, 0);
        chk("rst_cfg0_err", rsp_error, 0);
        chk("rst_cfg0_valid", rsp_valid, 1);
        req(0, 8'h04, 0);
        chk("rst_val0", rsp_rdata, 0);

        req(1, 8'h08, 32'h0000_0371);
        repeat (9) @(negedge clk);
        req(1, 8'h08, 32'h0);
        req(0, 8'h0C, 0);
        chk("cycles_c1", rsp_rdata, 10);

        req(1, 8'h00, 32'h0000_0231);
        pat = 8'b1011_0101;
        for (int i = 0; i < 8; i++) begin
            noise(pat[i]);
            @(negedge clk);
        end
        noise(0);
        req(1, 8'h00, 32'h0);
        ev = '0;
        req(0, 8'h04, 0);
        chk("events_c0", rsp_rdata, 5);

        req(1, 8'h14, 32'hFFFF_FFFE);
        req(1, 8'h10, 32'h0000_0073);
        @(negedge clk);
        req(1, 8'h10, 32'h0000_0072);
        chk("irq_not_yet", irq, 0);
        @(negedge clk);
        chk("irq_rise", irq, 1);
        req(0, 8'h14, 0);
        chk("wrap_val", rsp_rdata, 0);
        req(0, 8'h10, 0);
        chk("wrap_ovf", rsp_rdata, 32'h8000_0072);
        req(1, 8'h10, 32'h8000_0072);
        chk("irq_hold", irq, 1);
        @(negedge clk);
        chk("irq_drop", irq, 0);

        req(0, 8'h0C, 0);
        rsp_ready = 0;
        d0 = rsp_rdata;
        chk("bp_first", d0, 10);
        req_valid = 1; req_write = 0; req_addr = 8'h04;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_rdata, d0);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_next", rsp_rdata, 5);
        req(0, 8'h10, 0);
        chk("b2b_a", rsp_rdata, 32'h0000_0072);
        req(0, 8'h0C, 0);
        chk("b2b_b", rsp_rdata, 10);

        req(1, 8'h22, 32'hDEAD_BEEF);
        chk("mis_err", rsp_error, 1);
        chk("mis_data", rsp_rdata, 0);
        req(1, 8'h0E, 32'h1234_5678);
        chk("mis2_err", rsp_error, 1);
        req(0, NK * 8, 0);
        chk("oor_err", rsp_error, 1);
        chk("oor_data", rsp_rdata, 0);
        req(1, NK * 8, 32'hFFFF_FFFF);
        req(0, 8'h0C, 0);
        chk("err_nochange", rsp_rdata, 10);

        req(1, 8'h18, 32'h0000_0071);
        freeze = 1;
        req(1, 8'h1C, 32'd100);
        repeat (3) @(negedge clk);
        req(0, 8'h1C, 0);
        chk("freeze_val", rsp_rdata, 100);
        freeze = 0;

        for (int c = 0; c < 1500; c++) begin
            ev        = (NC * 7)'({$urandom, $urandom});
            freeze    = $urandom_range(0, 7) == 0;
            rsp_ready = $urandom_range(0, 3) != 0;
            req_valid = $urandom_range(0, 1);
            req_write = $urandom_range(0, 1);
            r = $urandom_range(0, 15);
            a = 8'($urandom_range(0, 3) * 8 + $urandom_range(0, 1) * 4);
            if (r == 0) a[0] = 1;
            if (r == 1) a = 8'($urandom_range(NK * 8, 255)) & 8'hFC;
            d = $urandom;
            if (!a[2]) d[15:8] = 8'($urandom_range(0, 11));
            else if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            req_addr  = a;
            req_wdata = d;
            @(negedge clk);
        end
        req_valid = 0;
        freeze    = 0;

        rsp_ready = 1;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 8'h04;
        @(negedge clk);
        req_valid = 0;
        rsp_ready = 0;
        chk("mid_pending", rsp_valid, 1);
        #3 rst_ni = 0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rdata", rsp_rdata, 0);
        chk("mid_irq", irq, 0);
        @(negedge clk);
        rst_ni = 1;
        rsp_ready = 1;
        @(negedge clk);
        req(0, 8'h04, 0);
        chk("post_rst_val0", rsp_rdata, 0);
        req(0, 8'h18, 0);
        chk("post_rst_cfg3", rsp_rdata, 0);
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
